ac_scan_ctrl: RTL and testbench

- Upstream sequencer for the Aho-Corasick goto/failure table reader.
- Accepts a text character stream over a valid/ready handshake and presents (current state, character) lookups to the table reader.
- On a goto hit: advances state. On a miss: follows failure transitions, re-presenting the same character.
- Emits match events carrying text position and accepting state; end of text is marked by a last flag.

---
 rtl/ac_pkg.sv | 24 ++
 rtl/ac_fail_guard.sv | 29 ++
 rtl/ac_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ac_scan_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// Types shared by the Aho-Corasick scan sequencer and the goto/failure table reader:
// default widths, root state, sequencer FSM encoding and the lookup response layout.
package ac_pkg;

  localparam int STATE_W = 8;
  localparam int CHAR_W  = 4;

  localparam logic [STATE_W-1:0] ROOT_STATE = '0;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } ac_fsm_e;

  // next is the goto target on a hit, the failure target on a miss
  typedef struct packed {
    logic               hit;
    logic               accept;
    logic [STATE_W-1:0] next;
  } lookup_rsp_t;

endpackage

// File: rtl/ac_fail_guard.sv
// Failure-hop counter for one text character; limit asserts once MAX_FAIL hops were taken.
// Latency: clr/inc take effect on the next clock edge; no backpressure (pure counter).
module ac_fail_guard #(
  parameter int MAX_FAIL = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit
);

  localparam int CNT_W = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;

  logic [CNT_W-1:0] fail_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt_q <= '0;
    end else if (clr) begin
      fail_cnt_q <= '0;
    end else if (inc && !limit) begin
      fail_cnt_q <= fail_cnt_q + CNT_W'(1);
    end
  end

  assign limit = (fail_cnt_q == CNT_W'(MAX_FAIL));

endmodule

// File: rtl/ac_scan_ctrl.sv
// Aho-Corasick scan sequencer: per-character goto/failure lookups, match and end-of-text events (MATCH_COUNT via AC_MATCH_COUNT_EN).
// Latency: char accept -> LOOKUP_EN next cycle; MATCH_VALID/CHAR_READY one cycle after LOOKUP_DONE.
// Backpressure: CHAR_READY stays low while a character is in flight; LOOKUP_DONE is awaited indefinitely.
module ac_scan_ctrl #(
  parameter int STATE_W  = ac_pkg::STATE_W,
  parameter int CHAR_W   = ac_pkg::CHAR_W,
  parameter int POS_W    = 16,
  parameter int MAX_FAIL = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [CHAR_W-1:0]  CHAR_IN,
  input  logic               CHAR_VALID,
  input  logic               CHAR_LAST,
  output logic               CHAR_READY,
  output logic               LOOKUP_EN,
  output logic [STATE_W-1:0] LOOKUP_STATE,
  output logic [CHAR_W-1:0]  LOOKUP_CHAR,
  input  logic               LOOKUP_DONE,
  input  logic               LOOKUP_HIT,
  input  logic [STATE_W-1:0] LOOKUP_NEXT,
  input  logic               LOOKUP_ACCEPT,
  output logic               MATCH_VALID,
  output logic [STATE_W-1:0] MATCH_STATE,
  output logic [POS_W-1:0]   MATCH_POS,
  output logic               TEXT_DONE,
  output logic               ERR_FAIL
`ifdef AC_MATCH_COUNT_EN
  ,
  output logic [POS_W-1:0]   MATCH_COUNT
`endif
);

  import ac_pkg::*;

  ac_fsm_e            state_q, state_d;
  logic [STATE_W-1:0] cur_state_q, cur_state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [CHAR_W-1:0]  char_q;
  logic               last_q;
  logic               char_ready_q;
  logic               match_vld_q;
  logic [STATE_W-1:0] match_state_q;
  logic [POS_W-1:0]   match_pos_q;
  logic               text_done_q;
  logic               err_fail_q;

  logic               accept_char;
  logic               consume;
  logic               match_d;
  logic               err_set;
  logic               fail_inc;
  logic               fail_limit;
  lookup_rsp_t        rsp;

  assign rsp         = '{hit: LOOKUP_HIT, accept: LOOKUP_ACCEPT, next: LOOKUP_NEXT};
  assign accept_char = (state_q == S_FETCH) && CHAR_VALID && char_ready_q;

  ac_fail_guard #(
    .MAX_FAIL (MAX_FAIL)
  ) u_fail_guard (
    .clk   (CLK),
    .rst   (RST),
    .clr   (accept_char),
    .inc   (fail_inc),
    .limit (fail_limit)
  );

  always_comb begin
    state_d     = state_q;
    cur_state_d = cur_state_q;
    pos_d       = pos_q;
    consume     = 1'b0;
    match_d     = 1'b0;
    err_set     = 1'b0;
    fail_inc    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (accept_char) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (LOOKUP_DONE) begin
          if (rsp.hit) begin
            cur_state_d = rsp.next;
            match_d     = rsp.accept;
            consume     = 1'b1;
          end else if (cur_state_q == ROOT_STATE) begin
            consume = 1'b1;
          end else if (!fail_limit) begin
            // retry the same character from the failure state
            cur_state_d = rsp.next;
            fail_inc    = 1'b1;
            state_d     = S_REQ;
          end else begin
            err_set     = 1'b1;
            cur_state_d = ROOT_STATE;
            consume     = 1'b1;
          end
          if (consume) begin
            pos_d   = pos_q + POS_W'(1);
            state_d = last_q ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: begin
        cur_state_d = ROOT_STATE;
        pos_d       = '0;
        state_d     = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_FETCH;
      cur_state_q   <= ROOT_STATE;
      pos_q         <= '0;
      char_q        <= '0;
      last_q        <= 1'b0;
      char_ready_q  <= 1'b0;
      match_vld_q   <= 1'b0;
      match_state_q <= '0;
      match_pos_q   <= '0;
      text_done_q   <= 1'b0;
      err_fail_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_state_q  <= cur_state_d;
      pos_q        <= pos_d;
      // registered so READY stays low through the reset cycle itself
      char_ready_q <= (state_d == S_FETCH);
      match_vld_q  <= match_d;
      text_done_q  <= (state_q == S_DONE);
      if (accept_char) begin
        char_q <= CHAR_IN;
        last_q <= CHAR_LAST;
      end
      if (match_d) begin
        match_state_q <= rsp.next;
        match_pos_q   <= pos_q;
      end
      if (err_set) err_fail_q <= 1'b1;
    end
  end

`ifdef AC_MATCH_COUNT_EN
  logic [POS_W-1:0] match_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || (state_q == S_DONE)) begin
      match_cnt_q <= '0;
    end else if (match_d && (match_cnt_q != '1)) begin
      match_cnt_q <= match_cnt_q + POS_W'(1);
    end
  end

  assign MATCH_COUNT = match_cnt_q;
`endif

  assign CHAR_READY   = char_ready_q;
  assign LOOKUP_EN    = (state_q == S_REQ);
  assign LOOKUP_STATE = cur_state_q;
  assign LOOKUP_CHAR  = char_q;
  assign MATCH_VALID  = match_vld_q;
  assign MATCH_STATE  = match_state_q;
  assign MATCH_POS    = match_pos_q;
  assign TEXT_DONE    = text_done_q;
  assign ERR_FAIL     = err_fail_q;

endmodule

// File: tb/tb_ac_scan_ctrl.sv
// Directed bench for ac_scan_ctrl: the bench plays the table reader with hand-picked responses.
module tb_ac_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  CHAR_IN;
  logic        CHAR_VALID;
  logic        CHAR_LAST;
  logic        CHAR_READY;
  logic        LOOKUP_EN;
  logic [7:0]  LOOKUP_STATE;
  logic [3:0]  LOOKUP_CHAR;
  logic        LOOKUP_DONE;
  logic        LOOKUP_HIT;
  logic [7:0]  LOOKUP_NEXT;
  logic        LOOKUP_ACCEPT;
  logic        MATCH_VALID;
  logic [7:0]  MATCH_STATE;
  logic [15:0] MATCH_POS;
  logic        TEXT_DONE;
  logic        ERR_FAIL;
`ifdef AC_MATCH_COUNT_EN
  logic [15:0] MATCH_COUNT;
`endif

  int checks = 0;
  int errors = 0;

  ac_scan_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .CHAR_IN       (CHAR_IN),
    .CHAR_VALID    (CHAR_VALID),
    .CHAR_LAST     (CHAR_LAST),
    .CHAR_READY    (CHAR_READY),
    .LOOKUP_EN     (LOOKUP_EN),
    .LOOKUP_STATE  (LOOKUP_STATE),
    .LOOKUP_CHAR   (LOOKUP_CHAR),
    .LOOKUP_DONE   (LOOKUP_DONE),
    .LOOKUP_HIT    (LOOKUP_HIT),
    .LOOKUP_NEXT   (LOOKUP_NEXT),
    .LOOKUP_ACCEPT (LOOKUP_ACCEPT),
    .MATCH_VALID   (MATCH_VALID),
    .MATCH_STATE   (MATCH_STATE),
    .MATCH_POS     (MATCH_POS),
    .TEXT_DONE     (TEXT_DONE),
    .ERR_FAIL      (ERR_FAIL)
`ifdef AC_MATCH_COUNT_EN
    ,
    .MATCH_COUNT   (MATCH_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one character and hold it until the DUT takes it (bounded).
  task automatic send_char(input logic [3:0] c, input logic last);
    int i;
    CHAR_IN    = c;
    CHAR_LAST  = last;
    CHAR_VALID = 1'b1;
    i = 0;
    while (!CHAR_READY && i < 20) begin
      tick();
      i++;
    end
    checks++;
    if (CHAR_READY !== 1'b1) begin
      errors++;
      $display("FAIL char_ready_timeout got %b exp 1 within 20 cycles", CHAR_READY);
    end
    tick();
    CHAR_VALID = 1'b0;
    CHAR_LAST  = 1'b0;
  endtask

  // Called in the S_REQ cycle: passes S_REQ, waits dly cycles, returns one response.
  task automatic give_resp(input logic hit, input logic acc, input logic [7:0] nxt, input int dly);
    tick();
    repeat (dly) tick();
    LOOKUP_DONE   = 1'b1;
    LOOKUP_HIT    = hit;
    LOOKUP_ACCEPT = acc;
    LOOKUP_NEXT   = nxt;
    tick();
    LOOKUP_DONE   = 1'b0;
    LOOKUP_HIT    = 1'b0;
    LOOKUP_ACCEPT = 1'b0;
    LOOKUP_NEXT   = 8'd0;
  endtask

  task automatic test_reset();
    logic [40:0] got;
    RST = 1'b1;
    repeat (3) tick();
    got = {CHAR_READY, LOOKUP_EN, MATCH_VALID, TEXT_DONE, ERR_FAIL,
           LOOKUP_STATE, LOOKUP_CHAR, MATCH_STATE, MATCH_POS};
    checks++;
    if (got !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", got);
    end
    RST = 1'b0;
    checks++;
    if (CHAR_READY !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low got %b exp 0", CHAR_READY);
    end
    tick();
    checks++;
    if (CHAR_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise got %b exp 1", CHAR_READY);
    end
  endtask

  // Table 0-C->1, 1-A->2 (accepting); text "C A".
  task automatic test_match();
    logic [13:0] lk;
    logic [2:0]  fl;
    logic [25:0] m;
    send_char(4'hC, 1'b0);
    lk = {LOOKUP_EN, CHAR_READY, LOOKUP_STATE, LOOKUP_CHAR};
    checks++;
    if (lk !== {1'b1, 1'b0, 8'd0, 4'hC}) begin
      errors++;
      $display("FAIL match_lookup1 got %h exp %h", lk, {1'b1, 1'b0, 8'd0, 4'hC});
    end
    give_resp(1'b1, 1'b0, 8'd1, 0);
    fl = {MATCH_VALID, CHAR_READY, LOOKUP_EN};
    checks++;
    if (fl !== 3'b010) begin
      errors++;
      $display("FAIL match_after_hit1 got %b exp 010", fl);
    end
    send_char(4'hA, 1'b1);
    lk = {LOOKUP_EN, CHAR_READY, LOOKUP_STATE, LOOKUP_CHAR};
    checks++;
    if (lk !== {1'b1, 1'b0, 8'd1, 4'hA}) begin
      errors++;
      $display("FAIL match_lookup2 got %h exp %h", lk, {1'b1, 1'b0, 8'd1, 4'hA});
    end
    give_resp(1'b1, 1'b1, 8'd2, 0);
    m = {MATCH_VALID, MATCH_STATE, MATCH_POS, TEXT_DONE};
    checks++;
    if (m !== {1'b1, 8'd2, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL match_event got %h exp %h", m, {1'b1, 8'd2, 16'd1, 1'b0});
    end
    tick();
    fl = {MATCH_VALID, TEXT_DONE, CHAR_READY};
    checks++;
    if (fl !== 3'b011) begin
      errors++;
      $display("FAIL match_text_done got %b exp 011", fl);
    end
    tick();
    checks++;
    if (TEXT_DONE !== 1'b0) begin
      errors++;
      $display("FAIL match_text_done_pulse got %b exp 0", TEXT_DONE);
    end
  endtask

  // Root miss on char 5 consumes with no retry; next match shows pos 1 from state 0.
  task automatic test_root_miss();
    logic [13:0] lk;
    logic [1:0]  fl;
    logic [24:0] m;
    send_char(4'h5, 1'b0);
    lk = {LOOKUP_EN, CHAR_READY, LOOKUP_STATE, LOOKUP_CHAR};
    checks++;
    if (lk !== {1'b1, 1'b0, 8'd0, 4'h5}) begin
      errors++;
      $display("FAIL root_lookup got %h exp %h", lk, {1'b1, 1'b0, 8'd0, 4'h5});
    end
    give_resp(1'b0, 1'b0, 8'd0, 0);
    fl = {LOOKUP_EN, CHAR_READY};
    checks++;
    if (fl !== 2'b01) begin
      errors++;
      $display("FAIL root_no_retry got %b exp 01", fl);
    end
    send_char(4'hC, 1'b1);
    checks++;
    if (LOOKUP_STATE !== 8'd0) begin
      errors++;
      $display("FAIL root_state_kept got %0d exp 0", LOOKUP_STATE);
    end
    give_resp(1'b1, 1'b1, 8'd7, 0);
    m = {MATCH_VALID, MATCH_STATE, MATCH_POS};
    checks++;
    if (m !== {1'b1, 8'd7, 16'd1}) begin
      errors++;
      $display("FAIL root_pos_advanced got %h exp %h", m, {1'b1, 8'd7, 16'd1});
    end
    tick();
    tick();
  endtask

  // Reach state 2, miss on char 3, fail to 1, 1-3->4 accepting.
  task automatic test_fail_retry();
    logic [13:0] lk;
    logic [24:0] m;
    send_char(4'hC, 1'b0);
    give_resp(1'b1, 1'b0, 8'd1, 0);
    send_char(4'hA, 1'b0);
    give_resp(1'b1, 1'b1, 8'd2, 0);
    send_char(4'h3, 1'b1);
    lk = {LOOKUP_EN, CHAR_READY, LOOKUP_STATE, LOOKUP_CHAR};
    checks++;
    if (lk !== {1'b1, 1'b0, 8'd2, 4'h3}) begin
      errors++;
      $display("FAIL retry_first got %h exp %h", lk, {1'b1, 1'b0, 8'd2, 4'h3});
    end
    give_resp(1'b0, 1'b0, 8'd1, 0);
    lk = {LOOKUP_EN, CHAR_READY, LOOKUP_STATE, LOOKUP_CHAR};
    checks++;
    if (lk !== {1'b1, 1'b0, 8'd1, 4'h3}) begin
      errors++;
      $display("FAIL retry_second got %h exp %h", lk, {1'b1, 1'b0, 8'd1, 4'h3});
    end
    give_resp(1'b1, 1'b1, 8'd4, 0);
    m = {MATCH_VALID, MATCH_STATE, MATCH_POS};
    checks++;
    if (m !== {1'b1, 8'd4, 16'd2}) begin
      errors++;
      $display("FAIL retry_match got %h exp %h", m, {1'b1, 8'd4, 16'd2});
    end
    tick();
    tick();
  endtask

  // Failure chain 5 -> 6 -> 6 ... never reaching root: 9 lookups then abort.
  task automatic test_fail_limit();
    int n;
    logic [1:0] fl;
    send_char(4'h1, 1'b0);
    give_resp(1'b1, 1'b0, 8'd5, 0);
    send_char(4'h2, 1'b0);
    n = LOOKUP_EN ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      give_resp(1'b0, 1'b0, 8'd6, 0);
      if (LOOKUP_EN) n++;
      else break;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL limit_lookups got %0d exp 9", n);
    end
    fl = {ERR_FAIL, CHAR_READY};
    checks++;
    if (fl !== 2'b11) begin
      errors++;
      $display("FAIL limit_err_ready got %b exp 11", fl);
    end
    send_char(4'h4, 1'b1);
    checks++;
    if (LOOKUP_STATE !== 8'd0) begin
      errors++;
      $display("FAIL limit_state_root got %0d exp 0", LOOKUP_STATE);
    end
    give_resp(1'b0, 1'b0, 8'd0, 0);
    tick();
    fl = {TEXT_DONE, ERR_FAIL};
    checks++;
    if (fl !== 2'b11) begin
      errors++;
      $display("FAIL limit_err_sticky got %b exp 11", fl);
    end
    tick();
  endtask

  // Response delayed 5 cycles: request held, no second LOOKUP_EN, no READY.
  task automatic test_slow_response();
    logic [13:0] lk;
    logic [1:0]  fl;
    send_char(4'h9, 1'b0);
    lk = {LOOKUP_EN, CHAR_READY, LOOKUP_STATE, LOOKUP_CHAR};
    checks++;
    if (lk !== {1'b1, 1'b0, 8'd0, 4'h9}) begin
      errors++;
      $display("FAIL slow_req got %h exp %h", lk, {1'b1, 1'b0, 8'd0, 4'h9});
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      lk = {LOOKUP_EN, CHAR_READY, LOOKUP_STATE, LOOKUP_CHAR};
      checks++;
      if (lk !== {1'b0, 1'b0, 8'd0, 4'h9}) begin
        errors++;
        $display("FAIL slow_hold_%0d got %h exp %h", i, lk, {1'b0, 1'b0, 8'd0, 4'h9});
      end
      tick();
    end
    LOOKUP_DONE = 1'b1;
    LOOKUP_HIT  = 1'b1;
    LOOKUP_NEXT = 8'd3;
    tick();
    LOOKUP_DONE = 1'b0;
    LOOKUP_HIT  = 1'b0;
    LOOKUP_NEXT = 8'd0;
    fl = {MATCH_VALID, CHAR_READY};
    checks++;
    if (fl !== 2'b01) begin
      errors++;
      $display("FAIL slow_done got %b exp 01", fl);
    end
  endtask

  // Reset while waiting in state 3, stray response afterwards, restart from root/pos 0.
  task automatic test_reset_mid_lookup();
    logic [40:0] got;
    logic [2:0]  fl;
    logic [24:0] m;
    send_char(4'h2, 1'b0);
    checks++;
    if (LOOKUP_STATE !== 8'd3) begin
      errors++;
      $display("FAIL rst_pre_state got %0d exp 3", LOOKUP_STATE);
    end
    tick();
    RST = 1'b1;
    tick();
    got = {CHAR_READY, LOOKUP_EN, MATCH_VALID, TEXT_DONE, ERR_FAIL,
           LOOKUP_STATE, LOOKUP_CHAR, MATCH_STATE, MATCH_POS};
    checks++;
    if (got !== 41'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h exp 0", got);
    end
    RST           = 1'b0;
    LOOKUP_DONE   = 1'b1;
    LOOKUP_HIT    = 1'b1;
    LOOKUP_ACCEPT = 1'b1;
    LOOKUP_NEXT   = 8'd9;
    tick();
    tick();
    fl = {MATCH_VALID, LOOKUP_EN, CHAR_READY};
    checks++;
    if (fl !== 3'b001) begin
      errors++;
      $display("FAIL rst_stray_done got %b exp 001", fl);
    end
    LOOKUP_DONE   = 1'b0;
    LOOKUP_HIT    = 1'b0;
    LOOKUP_ACCEPT = 1'b0;
    LOOKUP_NEXT   = 8'd0;
    send_char(4'hC, 1'b0);
    checks++;
    if (LOOKUP_STATE !== 8'd0) begin
      errors++;
      $display("FAIL rst_restart_state got %0d exp 0", LOOKUP_STATE);
    end
    give_resp(1'b1, 1'b1, 8'd1, 0);
    m = {MATCH_VALID, MATCH_STATE, MATCH_POS};
    checks++;
    if (m !== {1'b1, 8'd1, 16'd0}) begin
      errors++;
      $display("FAIL rst_restart_pos got %h exp %h", m, {1'b1, 8'd1, 16'd0});
    end
  endtask

  initial begin
    RST           = 1'b1;
    CHAR_IN       = 4'd0;
    CHAR_VALID    = 1'b0;
    CHAR_LAST     = 1'b0;
    LOOKUP_DONE   = 1'b0;
    LOOKUP_HIT    = 1'b0;
    LOOKUP_NEXT   = 8'd0;
    LOOKUP_ACCEPT = 1'b0;
    test_reset();
    test_match();
    test_root_miss();
    test_fail_retry();
    test_fail_limit();
    test_slow_response();
    test_reset_mid_lookup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
